// File: rtl/ldmac_round_ctrl.sv
// Round sequencer for the LDMAC bit-sliced SubCells datapath: four 16-bit lanes, rc addition, lane rotation.
// Optional feature: define LDMAC_ABORT_EN to honour the abort input; otherwise abort is ignored.
module ldmac_round_ctrl #(
  parameter int ROUNDS       = 28,
  parameter int SWITCH_ROUND = 28
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] din,
  output logic [15:0] sc_a0,
  output logic [15:0] sc_a1,
  output logic [15:0] sc_a2,
  output logic [15:0] sc_a3,
  output logic        sc_sbox_type,
  input  logic [15:0] sc_b0,
  input  logic [15:0] sc_b1,
  input  logic [15:0] sc_b2,
  input  logic [15:0] sc_b3,
  output logic        busy,
  output logic        done,
  output logic [63:0] dout,
  output logic [5:0]  round_idx
);

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);
  localparam logic [6:0] SW_IDX   = 7'(SWITCH_ROUND);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] lane0_q, lane1_q, lane2_q, lane3_q;
  logic [15:0] lane0_d, lane1_d, lane2_d, lane3_d;
  logic [5:0]  rc_q, rc_d;
  logic [5:0]  ridx_q, ridx_d;
  logic        busy_q;
  logic        done_q;
  logic        abort_w;

`ifdef LDMAC_ABORT_EN
  assign abort_w = abort;
`else
  wire unused_abort = abort;
  assign abort_w = 1'b0;
`endif

  function automatic logic [15:0] rotl16(input logic [15:0] x, input int unsigned n);
    return (x << n) | (x >> (16 - n));
  endfunction

  // 6-bit round-constant LFSR step: shift left, feedback rc[5]^rc[4]^1.
  function automatic logic [5:0] rc_next(input logic [5:0] rc);
    return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction

  always_comb begin
    lane0_d = sc_b0 ^ {10'b0, rc_q};
    lane1_d = rotl16(sc_b1, 1);
    lane2_d = rotl16(sc_b2, 2);
    lane3_d = rotl16(sc_b3, 3);
    rc_d    = rc_next(rc_q);
    ridx_d  = ridx_q + 6'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lane0_q <= '0;
      lane1_q <= '0;
      lane2_q <= '0;
      lane3_q <= '0;
      rc_q    <= '0;
      ridx_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start && !abort_w) begin
            lane3_q <= din[63:48];
            lane2_q <= din[47:32];
            lane1_q <= din[31:16];
            lane0_q <= din[15:0];
            rc_q    <= 6'h01;
            ridx_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort_w) begin
            // Partial lanes stay as they are; dout is meaningless until the next run.
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            lane0_q <= lane0_d;
            lane1_q <= lane1_d;
            lane2_q <= lane2_d;
            lane3_q <= lane3_d;
            rc_q    <= rc_d;
            ridx_q  <= ridx_d;
            if (ridx_q == LAST_IDX) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sc_a0        = lane0_q;
  assign sc_a1        = lane1_q;
  assign sc_a2        = lane2_q;
  assign sc_a3        = lane3_q;
  assign sc_sbox_type = busy_q & ({1'b0, ridx_q} < SW_IDX);
  assign busy         = busy_q;
  assign done         = done_q;
  assign dout         = {lane3_q, lane2_q, lane1_q, lane0_q};
  assign round_idx    = ridx_q;

endmodule

// File: tb/tb_ldmac_round_ctrl.sv
// Bench for ldmac_round_ctrl: several parameterisations driven by random runs against a round-level model.
module tb_ldmac_round_ctrl;
  localparam int NI = 5;
  localparam int RN [NI] = '{2, 1, 4, 28, 6};
  localparam int SWN[NI] = '{28, 28, 2, 28, 3};
`ifdef LDMAC_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [NI-1:0]        start_s, abort_s;
  logic [NI-1:0][63:0]  din_s;
  logic [NI-1:0][15:0]  msk;
  wire  [NI-1:0][15:0]  a0, a1, a2, a3;
  wire  [NI-1:0]        sbt, busy_s, done_s;
  wire  [NI-1:0][63:0]  dout_s;
  wire  [NI-1:0][5:0]   ridx;
  int total = 0;
  int bad   = 0;
  int rc_tab[64];

  always #5 clk = ~clk;

  // SubCells stand-in: identity when msk is 0, otherwise a fixed XOR mask on every lane.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    ldmac_round_ctrl #(.ROUNDS(RN[g]), .SWITCH_ROUND(SWN[g])) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_s[g]), .abort(abort_s[g]), .din(din_s[g]),
      .sc_a0(a0[g]), .sc_a1(a1[g]), .sc_a2(a2[g]), .sc_a3(a3[g]), .sc_sbox_type(sbt[g]),
      .sc_b0(a0[g] ^ msk[g]), .sc_b1(a1[g] ^ msk[g]), .sc_b2(a2[g] ^ msk[g]), .sc_b3(a3[g] ^ msk[g]),
      .busy(busy_s[g]), .done(done_s[g]), .dout(dout_s[g]), .round_idx(ridx[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rl(input logic [15:0] x, input int n);
    logic [31:0] t;
    t = {x, x} << n;
    return t[31:16];
  endfunction

  function automatic logic [63:0] model_round(input logic [63:0] s, input logic [15:0] m, input int rc);
    logic [15:0] l0, l1, l2, l3;
    l0 = (s[15:0]  ^ m) ^ 16'(rc);
    l1 = rl(s[31:16] ^ m, 1);
    l2 = rl(s[47:32] ^ m, 2);
    l3 = rl(s[63:48] ^ m, 3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [63:0] lanes(input int k);
    return {a3[k], a2[k], a1[k], a0[k]};
  endfunction

  task automatic run(input int k, input logic [63:0] d, input logic [15:0] m, input int ab_at, input bit hold);
    logic [63:0] st[0:64];
    int R;
    int n;
    R = RN[k];
    st[0] = d;
    for (int r = 0; r < R; r++) st[r+1] = model_round(st[r], m, rc_tab[r]);
    msk[k] = m;
    din_s[k] = d;
    start_s[k] = 1'b1;
    tick();
    if (!hold) start_s[k] = 1'b0;
    for (int c = 0; c < R; c++) begin
      chk("busy", busy_s[k], 64'd1);
      chk("round_idx", ridx[k], 64'(c));
      chk("sbox_type", sbt[k], 64'(c < SWN[k]));
      chk("lanes", lanes(k), st[c]);
      chk("done_in_run", done_s[k], 64'd0);
      if (c == ab_at) abort_s[k] = 1'b1;
      tick();
      abort_s[k] = 1'b0;
      if (ABORT_EN && c == ab_at) begin
        chk("abort_busy", busy_s[k], 64'd0);
        chk("abort_lanes", lanes(k), st[c]);
        for (int i = 0; i < 3; i++) begin
          chk("abort_no_done", done_s[k], 64'd0);
          tick();
        end
        return;
      end
    end
    chk("done", done_s[k], 64'd1);
    chk("busy_in_done", busy_s[k], 64'd0);
    chk("sbox_in_done", sbt[k], 64'd0);
    chk("dout", dout_s[k], st[R]);
    tick();
    chk("done_pulse_end", done_s[k], 64'd0);
    chk("idle_after_done", busy_s[k], 64'd0);
    if (!hold) begin
      chk("dout_hold", dout_s[k], st[R]);
    end else begin
      tick();
      chk("restart_busy", busy_s[k], 64'd1);
      chk("restart_idx", ridx[k], 64'd0);
      chk("restart_lanes", lanes(k), d);
      start_s[k] = 1'b0;
      n = 0;
      while (n < R + 3 && !done_s[k]) begin
        tick();
        n++;
      end
      chk("restart_latency", 64'(n), 64'(R));
      chk("restart_dout", dout_s[k], st[R]);
      tick();
    end
  endtask

  task automatic idle_abort(input int k);
    int n;
    din_s[k] = {$urandom, $urandom};
    msk[k] = '0;
    start_s[k] = 1'b1;
    abort_s[k] = 1'b1;
    tick();
    start_s[k] = 1'b0;
    abort_s[k] = 1'b0;
    chk("idle_abort_busy", busy_s[k], 64'(!ABORT_EN));
    if (ABORT_EN) begin
      tick();
      chk("idle_abort_still_idle", busy_s[k], 64'd0);
    end else begin
      n = 0;
      while (n < RN[k] + 3 && !done_s[k]) begin
        tick();
        n++;
      end
      chk("idle_abort_ignored_latency", 64'(n), 64'(RN[k]));
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int rc;
    int k, ab;
    logic [15:0] m;
    rc = 1;
    for (int i = 0; i < 64; i++) begin
      rc_tab[i] = rc;
      rc = ((rc * 2) & 62) | (((rc >> 5) & 1) ^ ((rc >> 4) & 1) ^ 1);
    end
    rst_n = 1'b0;
    start_s = '0;
    abort_s = '0;
    din_s = '0;
    msk = '0;
    #12;
    for (int i = 0; i < NI; i++) begin
      chk("rst_busy", busy_s[i], 64'd0);
      chk("rst_done", done_s[i], 64'd0);
      chk("rst_dout", dout_s[i], 64'd0);
      chk("rst_sbox", sbt[i], 64'd0);
      chk("rst_idx", ridx[i], 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run(0, 64'h0, 16'h0, -1, 1'b0);
    chk("two_round_dout", dout_s[0], 64'h0000_0000_0000_0002);
    run(1, 64'h8000_8000_8000_0000, 16'h0, -1, 1'b0);
    chk("rotation_dout", dout_s[1], 64'h0004_0002_0001_0001);
    run(2, {$urandom, $urandom}, 16'h0, -1, 1'b0);
    run(4, 64'h0, 16'h0, -1, 1'b0);
    chk("const_schedule_dout", dout_s[4], 64'h0000_0000_0000_002B);
    run(3, {$urandom, $urandom}, 16'h0, 2, 1'b0);
    run(3, {$urandom, $urandom}, 16'h0, -1, 1'b0);
    run(2, {$urandom, $urandom}, 16'h0, -1, 1'b1);
    idle_abort(4);

    // Asynchronous reset in the middle of a 28-round run.
    din_s[3] = {$urandom, $urandom};
    start_s[3] = 1'b1;
    tick();
    start_s[3] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy_s[3], 64'd0);
    chk("midrst_done", done_s[3], 64'd0);
    chk("midrst_dout", dout_s[3], 64'd0);
    chk("midrst_lanes", lanes(3), 64'd0);
    chk("midrst_sbox", sbt[3], 64'd0);
    chk("midrst_idx", ridx[3], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("midrst_no_done", done_s[3], 64'd0);
    end

    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(0, NI - 1);
      m = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, RN[k] - 1) : -1;
      run(k, {$urandom, $urandom}, m, ab, (ab < 0) && ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ldmac_round_ctrl.md
# ldmac_round_ctrl

Round sequencer for the bit-sliced SubCells datapath of the LDMAC core. Holds the 64-bit cipher state as four 16-bit lanes, presents it to an external SubCells instance each cycle, and folds the S-box output back through round-constant addition and lane rotation. It runs a fixed number of rounds and selects `sbox_type` per round. It exposes a start/busy/done handshake to the mode-level controller.

## Interface
- `ROUNDS`, 28: rounds per invocation; legal range 1..63.
- `SWITCH_ROUND`, 28: rounds with index < `SWITCH_ROUND` use `sbox_type`=1; later rounds use 0.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  load `din` and begin; sampled only in IDLE.
- `abort`  in  1  cancel a run in progress.
- `din`  in  64  initial state; lane3=`din[63:48]` … lane0=`din[15:0]`.
- `sc_a0..sc_a3`  out  16 each  current lanes 0..3 to SubCells.
- `sc_sbox_type`  out  1  S-box select to SubCells.
- `sc_b0..sc_b3`  in  16 each  SubCells outputs, combinational from `sc_a*`.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse after the final round.
- `dout`  out  64  final state `{lane3,lane2,lane1,lane0}`; valid from `done` until the next `start` is accepted.
- `round_idx`  out  6  index of the round being computed (0-based).

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**, with `start`=1 (and `abort`=0):
  - lanes <= `din`; rc <= 6'h01; `round_idx` <= 0.
  - Next state RUN.
- **RUN**, each cycle with `abort`=0, lanes are updated from `sc_b*`:
  - lane0 <= `sc_b0` ^ {10'b0, rc}
  - lane1 <= rotl16(`sc_b1`, 1)
  - lane2 <= rotl16(`sc_b2`, 2)
  - lane3 <= rotl16(`sc_b3`, 3)
  - rc <= {rc[4:0], rc[5]^rc[4]^1}; sequence is 01, 03, 07, 0F, 1F, 3E, …
  - `round_idx` increments.
  - When `round_idx` = `ROUNDS`-1, the update still occurs and the next state is DONE.
- **DONE**: `done`=1 for exactly this cycle; next state IDLE. A `start` in DONE is ignored.
- `sc_a*` always equal the lane registers.
- `sc_sbox_type` = `busy` & (`round_idx` < `SWITCH_ROUND`); it is 0 outside RUN.
- `start` while in RUN or DONE is ignored.
- **`abort` in RUN**:
  - Next state IDLE; no `done` pulse.
  - Lanes keep their partial value; `dout` is not valid.
- **`abort` in IDLE, including together with `start`**: `abort` wins and no run begins.
- **`abort` in DONE**: no effect; the `done` pulse still occurs.
- **Reset**: all lanes, rc, `round_idx`, `busy`, `done` = 0; `dout`=0; `sc_sbox_type`=0; state IDLE.
- **Reset asserted mid-run**: immediate return to the reset values; no `done`.

## Timing
- `start` sampled at edge 0 → `busy`=1 from edge 0 to edge `ROUNDS`.
- `done`=1 for the cycle following edge `ROUNDS`, i.e. latency `ROUNDS`+1 cycles from `start` to `done`.
- Back-to-back throughput: one invocation per `ROUNDS`+2 cycles, since `start` is accepted only once the block is back in IDLE after DONE.
- SubCells is combinational within the round cycle; there is no extra pipeline stage.

## Configuration
- `LDMAC_ABORT_EN` defined: `abort` behaves as described above.
- `LDMAC_ABORT_EN` undefined:
  - The `abort` port remains but is ignored.
  - Every accepted `start` runs to completion and produces `done`.

## Test plan
Tests use an identity SubCells stub (`sc_b*`=`sc_a*`) unless noted.
- **Two-round run**: `ROUNDS`=2, `din`=0, `start` → `done` 3 cycles after `start`, `dout`=64'h0000_0000_0000_0002.
- **Lane rotation**: `ROUNDS`=1, `din`=64'h8000_8000_8000_0000 → `dout`=64'h0004_0002_0001_0001.
- **S-box select**: `ROUNDS`=4, `SWITCH_ROUND`=2 → `sc_sbox_type` over the RUN cycles is 1,1,0,0, and 0 in IDLE/DONE.
- **Abort**:
  - Abort in round 3 of 28 → `busy` drops the next cycle; no `done`.
  - A following `start` runs a full 28 rounds, with `done` at 29 cycles.
  - With the macro undefined, the same abort is ignored and `done` occurs at 29 cycles.
- **Reset and busy start**:
  - `rst_n` pulsed low mid-run → all outputs 0 immediately, state IDLE.
  - `start` held high through a whole run → exactly one run per acceptance; a new run begins only from IDLE.
- **Constant schedule**: `ROUNDS`=6, `din`=0 → lane0 after each round is 01, 02, 05, 0A, 15, 2B, so `dout`=64'h0000_0000_0000_002B.
